// File: rtl/r5fp_int_div_sqrt_issuer.sv
// rtl/r5fp_int_div_sqrt_issuer.sv - tagged div/sqrt request queue and single-op issuer
// Requests are queued, issued one at a time over strobe/done, and returned through a result register.

module r5fp_issuer_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          in_ready,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic          do_push, do_pop, full_d;

  assign do_push  = push & in_ready;
  assign do_pop   = pop & ~empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_d = wr_ptr + PW'(do_push);
  assign rd_ptr_d = rd_ptr + PW'(do_pop);
  // in_ready is registered from the post-update pointers, so a pop never frees a slot in the same cycle
  assign full_d   = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      in_ready <= ~full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

module r5fp_int_div_sqrt_issuer #(
  parameter int W       = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_is_div_i,
  input  logic [W-1:0]     req_D_i,
  input  logic [W-1:0]     req_N_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic [W-1:0]     dsq_D_o,
  output logic [W-1:0]     dsq_N_o,
  output logic             dsq_is_div_o,
  output logic             dsq_strobe_o,
  input  logic             dsq_ready_i,
  input  logic             dsq_done_i,
  input  logic [W-1:0]     dsq_quo_i,
  input  logic [W-1:0]     dsq_rem_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [W-1:0]     res_quo_o,
  output logic [W-1:0]     res_rem_o,
  output logic             res_is_div_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o,
  output logic             err_timeout_o
);
  localparam int EW = 1 + 2 * W + TAG_W;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state, state_d;
  logic             pop, fifo_empty, done_in_wait;
  logic [EW-1:0]    head;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt, cnt_d;

  r5fp_issuer_req_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid_i),
    .push_data ({req_is_div_i, req_D_i, req_N_i, req_tag_i}),
    .in_ready  (req_ready_o),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    dsq_strobe_o = 1'b0;
    done_in_wait = 1'b0;
    cnt_d        = cnt;
    case (state)
      IDLE: begin
        // holding off while a result is unread guarantees the next done has somewhere to land
        if (!fifo_empty && !res_valid_o) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (dsq_ready_i) begin
          dsq_strobe_o = 1'b1;
          cnt_d        = CW'(1);
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (dsq_done_i) begin
          done_in_wait = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else if (cnt != TIMEOUT_C) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dsq_is_div_o <= 1'b0;
      dsq_D_o      <= '0;
      dsq_N_o      <= '0;
      tag_q        <= '0;
    end else if (pop) begin
      {dsq_is_div_o, dsq_D_o, dsq_N_o, tag_q} <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_o  <= 1'b0;
      res_quo_o    <= '0;
      res_rem_o    <= '0;
      res_is_div_o <= 1'b0;
      res_tag_o    <= '0;
    end else if (done_in_wait) begin
      res_valid_o  <= 1'b1;
      res_quo_o    <= dsq_quo_i;
      res_rem_o    <= dsq_rem_i;
      res_is_div_o <= dsq_is_div_o;
      res_tag_o    <= tag_q;
    end else if (res_valid_o && res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  // set on the edge the counter becomes TIMEOUT, so the flag shows in the same cycle as that count
  always_ff @(posedge clk) begin
    if (reset) begin
      err_timeout_o <= 1'b0;
    end else if (state != IDLE && cnt_d == TIMEOUT_C) begin
      err_timeout_o <= 1'b1;
    end
  end

  assign busy_o = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_r5fp_int_div_sqrt_issuer.sv
// tb/tb_r5fp_int_div_sqrt_issuer.sv - directed bench with a unit stub and a request-order result model
module tb_r5fp_int_div_sqrt_issuer;
  localparam int W = 8, DEPTH = 4, TAG_W = 4, TIMEOUT = 64;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid_i = 1'b0, req_ready_o, req_is_div_i = 1'b0;
  logic [W-1:0] req_D_i = '0, req_N_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic [W-1:0] dsq_D_o, dsq_N_o;
  logic dsq_is_div_o, dsq_strobe_o;
  logic dsq_ready_i = 1'b0, dsq_done_i = 1'b0;
  logic [W-1:0] dsq_quo_i = '0, dsq_rem_i = '0;
  logic res_valid_o, res_ready_i = 1'b1;
  logic [W-1:0] res_quo_o, res_rem_o;
  logic res_is_div_o;
  logic [TAG_W-1:0] res_tag_o;
  logic busy_o, err_timeout_o;

  always #5 clk = ~clk;

  r5fp_int_div_sqrt_issuer #(.W(W), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_is_div_i(req_is_div_i),
    .req_D_i(req_D_i), .req_N_i(req_N_i), .req_tag_i(req_tag_i),
    .dsq_D_o(dsq_D_o), .dsq_N_o(dsq_N_o), .dsq_is_div_o(dsq_is_div_o),
    .dsq_strobe_o(dsq_strobe_o), .dsq_ready_i(dsq_ready_i), .dsq_done_i(dsq_done_i),
    .dsq_quo_i(dsq_quo_i), .dsq_rem_i(dsq_rem_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_quo_o(res_quo_o),
    .res_rem_o(res_rem_o), .res_is_div_o(res_is_div_o), .res_tag_o(res_tag_o),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  typedef struct {
    logic [3:0] tag;
    logic       is_div;
    logic [7:0] d, n, quo, rem;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t model(input logic is_div, input logic [7:0] d, input logic [7:0] n,
                                 input logic [3:0] tag);
    exp_t e;
    int x, r;
    e.tag = tag; e.is_div = is_div; e.d = d; e.n = n;
    if (is_div) begin
      e.quo = n / d;
      e.rem = n % d;
    end else begin
      x = int'(d) * 256;
      r = isqrt(x);
      e.quo = r[7:0];
      e.rem = 8'(x - r * r);
    end
    return e;
  endfunction

  // unit stub: latency lat cycles from strobe to done; mode 1 never answers
  int lat = 3, stub_mode = 0, inject_req = 0, inject_ack = 0;
  logic stall = 1'b0;
  logic strobe_seen = 1'b0, s_div = 1'b0;
  logic [7:0] s_d = '0, s_n = '0, u_q = '0, u_r = '0;
  int strobe_count = 0, strobe_cyc = -1;
  logic u_busy = 1'b0;
  int u_left = 0;

  always @(negedge clk) begin
    strobe_seen = dsq_strobe_o;
    s_d = dsq_D_o; s_n = dsq_N_o; s_div = dsq_is_div_o;
    if (dsq_strobe_o) begin
      strobe_count++;
      strobe_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    dsq_done_i = 1'b0;
    dsq_quo_i = ~u_q;
    dsq_rem_i = ~u_r;
    if (stub_mode != 0) begin
      u_busy = 1'b0;
    end else if (strobe_seen) begin
      if (s_div) begin
        u_q = s_n / s_d; u_r = s_n % s_d;
      end else begin
        u_q = 8'(isqrt(int'(s_d) * 256));
        u_r = 8'(int'(s_d) * 256 - int'(u_q) * int'(u_q));
      end
      u_left = lat - 1;
      if (u_left == 0) begin
        dsq_done_i = 1'b1; dsq_quo_i = u_q; dsq_rem_i = u_r;
      end else u_busy = 1'b1;
    end else if (u_busy) begin
      u_left--;
      if (u_left == 0) begin
        u_busy = 1'b0;
        dsq_done_i = 1'b1; dsq_quo_i = u_q; dsq_rem_i = u_r;
      end
    end
    if (inject_req != inject_ack) begin
      inject_ack = inject_req;
      dsq_done_i = 1'b1; dsq_quo_i = 8'hEE; dsq_rem_i = 8'hEE;
    end
    dsq_ready_i = !stall && !u_busy;
  end

  // result checker: order, values, sqrt bound, and hold-stability under backpressure
  logic pv = 1'b0, pr = 1'b0, pdiv = 1'b0;
  logic [7:0] pq = '0, prm = '0;
  logic [3:0] ptag = '0;
  int res_count = 0, rise_cyc = -1;
  int last_quo = -1, last_rem = -1, last_tag = -1, last_div = -1;

  always @(negedge clk) begin
    exp_t e;
    int dv, q;
    if (!reset) begin
      if (pv && !pr && res_valid_o) begin
        check("hold_quo", int'(res_quo_o), int'(pq));
        check("hold_rem", int'(res_rem_o), int'(prm));
        check("hold_tag", int'(res_tag_o), int'(ptag));
        check("hold_div", int'(res_is_div_o), int'(pdiv));
      end
      if (res_valid_o && !pv) rise_cyc = cyc;
      if (res_valid_o && res_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", int'(res_valid_o), 0);
        end else begin
          e = exp_q.pop_front();
          check("res_tag", int'(res_tag_o), int'(e.tag));
          check("res_is_div", int'(res_is_div_o), int'(e.is_div));
          check("res_quo", int'(res_quo_o), int'(e.quo));
          check("res_rem", int'(res_rem_o), int'(e.rem));
          if (!e.is_div) begin
            dv = int'(e.d) * 256;
            q = int'(res_quo_o);
            check("sqrt_bound", int'((q * q <= dv) && (dv < (q + 1) * (q + 1))), 1);
          end
          res_count++;
          last_quo = int'(res_quo_o); last_rem = int'(res_rem_o);
          last_tag = int'(res_tag_o); last_div = int'(res_is_div_o);
        end
      end
    end
    pv = res_valid_o; pr = res_ready_i;
    pq = res_quo_o; prm = res_rem_o; ptag = res_tag_o; pdiv = res_is_div_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic is_div, input logic [7:0] d, input logic [7:0] n,
                      input logic [3:0] tag, output int pc);
    bit acc = 1'b0;
    int b = 0;
    pc = -1;
    req_valid_i = 1'b1; req_is_div_i = is_div; req_D_i = d; req_N_i = n; req_tag_i = tag;
    while (!acc && b < 400) begin
      @(negedge clk);
      acc = req_ready_o;
      if (acc) pc = cyc;
      tick();
      b++;
    end
    req_valid_i = 1'b0;
    check("push_accept", int'(acc), 1);
    if (acc) exp_q.push_back(model(is_div, d, n, tag));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int b = 0;
    while (b < budget && (exp_q.size() != 0 || busy_o || res_valid_o)) begin
      @(negedge clk);
      b++;
    end
    check(name, int'(exp_q.size() == 0 && !busy_o && !res_valid_o), 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pc, base_s, base_r, s, b;
    logic [7:0] dd;

    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", int'(req_ready_o), 0);
    check("rst_res_valid", int'(res_valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_err", int'(err_timeout_o), 0);
    check("rst_strobe", int'(dsq_strobe_o), 0);
    check("rst_dsq_d", int'(dsq_D_o), 0);
    check("rst_res_quo", int'(res_quo_o), 0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("ready_after_reset", int'(req_ready_o), 1);
    tick();

    // single sqrt, latency and literal result
    lat = 4;
    push(1'b0, 8'h20, 8'h00, 4'd3, pc);
    wait_idle("t1_drain", 200);
    check("t1_strobe_cycle", strobe_cyc, pc + 2);
    check("t1_valid_cycle", rise_cyc, pc + 3 + lat);
    check("t1_strobes", strobe_count, 1);
    check("t1_quo", last_quo, 'h5A);
    check("t1_rem", last_rem, 'h5C);
    check("t1_tag", last_tag, 3);
    check("t1_is_div", last_div, 0);

    // divides
    lat = 2;
    push(1'b1, 8'd7, 8'd200, 4'd5, pc);
    push(1'b1, 8'd1, 8'd0, 4'd7, pc);
    push(1'b1, 8'd16, 8'd255, 4'd6, pc);
    wait_idle("div_drain", 300);
    check("div_quo", last_quo, 15);
    check("div_rem", last_rem, 15);
    check("div_tag", last_tag, 6);

    // sqrt sweep
    lat = 3;
    base_r = res_count;
    for (int d = 'h20; d <= 'hFF; d++) begin
      dd = 8'(d);
      push(1'b0, dd, dd ^ 8'h5A, dd[3:0], pc);
    end
    wait_idle("sweep_drain", 5000);
    check("sweep_count", res_count - base_r, 224);

    // fill with the unit stalled
    stall = 1'b1;
    lat = 2;
    base_s = strobe_count;
    base_r = res_count;
    for (int i = 0; i < 5; i++) push(1'b1, 8'd3, 8'(10 * i + 1), 4'(i), pc);
    @(negedge clk);
    check("fill_full", int'(req_ready_o), 0);
    check("fill_busy", int'(busy_o), 1);
    check("fill_no_strobe", strobe_count, base_s);
    tick();
    stall = 1'b0;
    wait_idle("fill_drain", 400);
    check("fill_count", res_count - base_r, 5);
    check("fill_last_tag", last_tag, 4);

    // result backpressure
    res_ready_i = 1'b0;
    base_s = strobe_count;
    push(1'b0, 8'h90, 8'h00, 4'd8, pc);
    push(1'b0, 8'hC4, 8'h00, 4'd9, pc);
    b = 0;
    while (!res_valid_o && b < 100) begin @(negedge clk); b++; end
    check("bp_first_valid", int'(res_valid_o), 1);
    repeat (20) @(negedge clk);
    check("bp_one_strobe", strobe_count, base_s + 1);
    check("bp_still_valid", int'(res_valid_o), 1);
    tick();
    res_ready_i = 1'b1;
    wait_idle("bp_drain", 200);
    check("bp_two_strobes", strobe_count, base_s + 2);
    check("bp_last_tag", last_tag, 9);

    // timeout
    stub_mode = 1;
    base_s = strobe_count;
    push(1'b0, 8'h40, 8'h00, 4'd9, pc);
    b = 0;
    while (strobe_count == base_s && b < 50) begin @(negedge clk); b++; end
    check("to_strobe", strobe_count, base_s + 1);
    s = strobe_cyc;
    b = 0;
    while (cyc < s + TIMEOUT - 1 && b < 200) begin @(negedge clk); b++; end
    check("to_before", int'(err_timeout_o), 0);
    @(negedge clk);
    check("to_at_limit", int'(err_timeout_o), 1);
    repeat (10) @(negedge clk);
    check("to_sticky", int'(err_timeout_o), 1);
    check("to_busy", int'(busy_o), 1);
    do_reset();
    @(negedge clk);
    check("to_cleared", int'(err_timeout_o), 0);
    tick();

    // reset in WAIT with two queued, then a late done
    base_s = strobe_count;
    push(1'b0, 8'h50, 8'h00, 4'd1, pc);
    push(1'b0, 8'h60, 8'h00, 4'd2, pc);
    push(1'b0, 8'h70, 8'h00, 4'd3, pc);
    b = 0;
    while (strobe_count == base_s && b < 50) begin @(negedge clk); b++; end
    check("rw_strobe", strobe_count, base_s + 1);
    check("rw_busy_before", int'(busy_o), 1);
    tick();
    do_reset();
    @(negedge clk);
    check("rw_busy", int'(busy_o), 0);
    check("rw_res_valid", int'(res_valid_o), 0);
    tick();
    inject_req++;
    repeat (10) @(negedge clk);
    check("rw_no_result", int'(res_valid_o), 0);
    check("rw_no_strobe", strobe_count, base_s + 1);
    check("rw_idle", int'(busy_o), 0);
    tick();

    // recovery after reset
    stub_mode = 0;
    lat = 5;
    push(1'b1, 8'd9, 8'd100, 4'hA, pc);
    wait_idle("rec_drain", 200);
    check("rec_quo", last_quo, 11);
    check("rec_rem", last_rem, 1);
    check("rec_tag", last_tag, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
